user_str_loopback: RTL and testbench

USER_STR_LOOPBACK -- requirements
Module: user_str_loopback

---
 rtl/user_str_pkg.sv | 19 +
 rtl/str_sync_fifo.sv | 67 ++++++
 rtl/user_str_loopback.sv | 152 +++++++++++++++
 tb/tb_user_str_loopback.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_str_pkg.sv
// Register map, CTRL bit positions and interrupt FSM encoding
// shared by the loopback top and its bench.
package user_str_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_THRESH = 4'h4;
    localparam logic [3:0] OFF_OCC    = 4'h8;
    localparam logic [3:0] OFF_XFER   = 4'hC;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } intr_state_e;

endpackage

// File: rtl/str_sync_fifo.sv
// Single-clock fall-through FIFO; flush empties it and
// overrides any push or pop in the same cycle.
module str_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = count_q[DEPTH_LOG2];
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/user_str_loopback.sv
// Host stream loopback through a FIFO with a small register window.
// Interrupt FSM and THRESH only with USER_STR_LOOPBACK_INTR_EN.
module user_str_loopback
    import user_str_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [19:0] BASE_ADDR  = 20'h00100
) (
    input  logic        i_user_clk,
    input  logic        i_rst_n,
    input  logic        i_pcie_str_data_valid,
    output logic        o_pcie_str_ack,
    input  logic [63:0] i_pcie_str_data,
    output logic        o_pcie_str_data_valid,
    input  logic        i_pcie_str_ack,
    output logic [63:0] o_pcie_str_data,
    input  logic [19:0] i_user_addr,
    input  logic [31:0] i_user_data,
    input  logic        i_user_wr_req,
    input  logic        i_user_rd_req,
    output logic [31:0] o_user_data,
    output logic        o_user_rd_ack,
    output logic        o_intr_req,
    input  logic        i_intr_ack
);

    logic                enable_q, enable_d;
    logic [31:0]         xfer_q, xfer_d;
    logic                rd_ack_q;
    logic [31:0]         rd_data_q, rdata;
    logic                in_win, wr_ctrl, flush;
    logic [3:0]          offset;
    logic                push, pop, full, empty;
    logic [DEPTH_LOG2:0] occ;
    logic [31:0]         thresh32;
    logic                unused_ok;

    assign in_win  = (i_user_addr[19:4] == BASE_ADDR[19:4]);
    assign offset  = i_user_addr[3:0];
    assign wr_ctrl = i_user_wr_req && in_win && (offset == OFF_CTRL);
    assign flush   = wr_ctrl && i_user_data[CTRL_FLUSH];

    // Reset gating keeps ack low while held in reset.
    assign o_pcie_str_ack = i_rst_n && enable_q && !full && !flush;
    assign o_pcie_str_data_valid = enable_q && !empty;

    assign push = i_pcie_str_data_valid && o_pcie_str_ack;
    assign pop  = o_pcie_str_data_valid && i_pcie_str_ack;

    str_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (64)
    ) u_fifo (
        .i_clk   (i_user_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_data  (i_pcie_str_data),
        .o_data  (o_pcie_str_data),
        .o_full  (full),
        .o_empty (empty),
        .o_count (occ)
    );

    always_comb begin
        enable_d = wr_ctrl ? i_user_data[CTRL_EN] : enable_q;
        xfer_d   = xfer_q;
        if (flush)    xfer_d = '0;
        else if (pop) xfer_d = xfer_q + 32'd1;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:   rdata[CTRL_EN] = enable_q;
            OFF_THRESH: rdata = thresh32;
            OFF_OCC:    rdata = 32'(occ);
            OFF_XFER:   rdata = xfer_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q  <= 1'b1;
            xfer_q    <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            enable_q  <= enable_d;
            xfer_q    <= xfer_d;
            rd_ack_q  <= i_user_rd_req && in_win;
            rd_data_q <= (i_user_rd_req && in_win) ? rdata : '0;
        end
    end

    assign o_user_rd_ack = rd_ack_q;
    assign o_user_data   = rd_data_q;

`ifdef USER_STR_LOOPBACK_INTR_EN
    localparam logic [DEPTH_LOG2:0] THRESH_RST =
        (DEPTH_LOG2+1)'(1 << (DEPTH_LOG2 - 1));

    intr_state_e         state_q, state_d;
    logic [DEPTH_LOG2:0] thresh_q, thresh_d;
    logic                wr_thresh;

    assign wr_thresh = i_user_wr_req && in_win && (offset == OFF_THRESH);
    assign thresh_d  = wr_thresh ? i_user_data[DEPTH_LOG2:0] : thresh_q;
    assign thresh32  = 32'(thresh_q);

    // Request is raised in the same cycle occupancy reaches THRESH.
    always_comb begin
        state_d    = state_q;
        o_intr_req = 1'b0;
        unique case (state_q)
            ST_ARMED: begin
                if (occ >= thresh_q) begin
                    o_intr_req = 1'b1;
                    state_d    = i_intr_ack ? ST_WAIT_LOW : ST_REQ;
                end
            end
            ST_REQ: begin
                o_intr_req = 1'b1;
                if (i_intr_ack) state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (occ < thresh_q) state_d = ST_ARMED;
            end
            default: state_d = ST_ARMED;
        endcase
        if (flush) state_d = ST_ARMED;
    end

    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_ARMED;
            thresh_q <= THRESH_RST;
        end else begin
            state_q  <= state_d;
            thresh_q <= thresh_d;
        end
    end
`else
    assign o_intr_req = 1'b0;
    assign thresh32   = '0;
`endif

    assign unused_ok = ^{i_intr_ack, i_user_data};

endmodule

// File: tb/tb_user_str_loopback.sv
// Directed bench for user_str_loopback: stream order, backpressure,
// flush, enable, register window, interrupt and async reset.
module tb_user_str_loopback;

    localparam logic [19:0] BASE   = 20'h00100;
    localparam logic [19:0] A_CTRL = BASE + 20'h0;
    localparam logic [19:0] A_THR  = BASE + 20'h4;
    localparam logic [19:0] A_OCC  = BASE + 20'h8;
    localparam logic [19:0] A_XFER = BASE + 20'hC;
`ifdef USER_STR_LOOPBACK_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ack;
    logic [63:0] in_data;
    logic        out_valid, out_ack;
    logic [63:0] out_data;
    logic [19:0] addr;
    logic [31:0] wdata, rdata;
    logic        wr_req, rd_req, rd_ack;
    logic        intr_req, intr_ack;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    user_str_loopback dut (
        .i_user_clk            (clk),
        .i_rst_n               (rst_n),
        .i_pcie_str_data_valid (in_valid),
        .o_pcie_str_ack        (in_ack),
        .i_pcie_str_data       (in_data),
        .o_pcie_str_data_valid (out_valid),
        .i_pcie_str_ack        (out_ack),
        .o_pcie_str_data       (out_data),
        .i_user_addr           (addr),
        .i_user_data           (wdata),
        .i_user_wr_req         (wr_req),
        .i_user_rd_req         (rd_req),
        .o_user_data           (rdata),
        .o_user_rd_ack         (rd_ack),
        .o_intr_req            (intr_req),
        .i_intr_ack            (intr_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w, input string tag);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        check(tag, 64'(in_ack), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic reg_write(input logic [19:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic reg_read(input logic [19:0] a, input logic [31:0] exp,
                            input string tag);
        addr   = a;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_ack"}, 64'(rd_ack), 64'd1);
        check(tag, 64'(rdata), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ack = 1'b0;
        addr = '0; wdata = '0; wr_req = 1'b0; rd_req = 1'b0;
        intr_ack = 1'b0;
        #12;
        check("rst_in_ack", 64'(in_ack), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_user_data", 64'(rdata), 64'd0);
        check("rst_intr", 64'(intr_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        reg_read(A_CTRL, 32'd1, "ctrl_reset");
        reg_read(A_THR, INTR ? 32'd8 : 32'd0, "thresh_reset");
        reg_read(A_OCC, 32'd0, "occ_reset");

        // five words held back, then drained in order
        push(64'h1, "p1_ack");
        check("fallthrough_valid", 64'(out_valid), 64'd1);
        check("fallthrough_data", out_data, 64'h1);
        for (int i = 2; i <= 5; i++) push(64'(i), "p5_ack");
        reg_read(A_OCC, 32'd5, "occ5");
        out_ack = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check("drain5_valid", 64'(out_valid), 64'd1);
            check("drain5_data", out_data, 64'(i));
            tick();
        end
        out_ack = 1'b0;
        check("drain5_empty", 64'(out_valid), 64'd0);
        reg_read(A_OCC, 32'd0, "occ0");
        reg_read(A_XFER, 32'd5, "xfer5");

        // fill to 16, 17th waits for one pop
        for (int i = 0; i < 16; i++) push(64'hA0 + 64'(i), "fill_ack");
        in_valid = 1'b1;
        in_data  = 64'hBEEF;
        #1;
        check("full_ack", 64'(in_ack), 64'd0);
        tick();
        in_valid = 1'b0;
        reg_read(A_OCC, 32'd16, "occ16");
        in_valid = 1'b1;
        out_ack  = 1'b1;
        #1;
        check("full_pop_ack", 64'(in_ack), 64'd0);
        check("full_pop_head", out_data, 64'hA0);
        tick();
        out_ack = 1'b0;
        #1;
        check("after_pop_ack", 64'(in_ack), 64'd1);
        tick();
        in_valid = 1'b0;
        out_ack  = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("drain16_data", out_data, 64'hA0 + 64'(i));
            tick();
        end
        check("drain16_last", out_data, 64'hBEEF);
        tick();
        out_ack = 1'b0;
        check("drain16_empty", 64'(out_valid), 64'd0);

        // 100 cycles of streaming
        in_valid = 1'b1;
        out_ack  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 64'h1000 + 64'(i);
            #1;
            if (i > 0) begin
                check("stream_valid", 64'(out_valid), 64'd1);
                check("stream_data", out_data, 64'h1000 + 64'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_last", out_data, 64'h1000 + 64'd99);
        tick();
        out_ack = 1'b0;
        reg_read(A_OCC, 32'd0, "stream_occ");
        reg_read(A_XFER, 32'd122, "stream_xfer");

        // disable stalls both sides and keeps state
        push(64'h55, "en_p1");
        push(64'h66, "en_p2");
        reg_write(A_CTRL, 32'd0);
        in_valid = 1'b1;
        out_ack  = 1'b1;
        #1;
        check("dis_in_ack", 64'(in_ack), 64'd0);
        check("dis_out_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        out_ack  = 1'b0;
        reg_read(A_OCC, 32'd2, "dis_occ");
        reg_read(A_XFER, 32'd122, "dis_xfer");
        reg_write(A_CTRL, 32'd1);
        check("reen_head", out_data, 64'h55);

        // flush with 8 held and a push in the same cycle
        for (int i = 0; i < 6; i++) push(64'h70 + 64'(i), "fl_fill");
        reg_read(A_OCC, 32'd8, "occ8");
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        addr     = A_CTRL;
        wdata    = 32'h3;
        wr_req   = 1'b1;
        #1;
        check("flush_in_ack", 64'(in_ack), 64'd0);
        tick();
        wr_req   = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        reg_read(A_OCC, 32'd0, "flush_occ");
        reg_read(A_XFER, 32'd0, "flush_xfer");
        reg_read(A_CTRL, 32'd1, "flush_selfclr");

        // register window edges
        reg_read(BASE + 20'h2, 32'd0, "unmapped");
        tick();
        check("ack_one_cycle", 64'(rd_ack), 64'd0);
        addr   = BASE + 20'h10;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("oow_no_ack", 64'(rd_ack), 64'd0);
        reg_write(A_OCC, 32'h5);
        reg_write(20'h00000, 32'h0);
        reg_read(A_OCC, 32'd0, "ro_ignored");
        reg_read(A_CTRL, 32'd1, "oow_wr_ignored");
        reg_write(A_THR, 32'd4);
        reg_read(A_THR, INTR ? 32'd4 : 32'd0, "thresh_wr");

        // interrupt at THRESH=4
        push(64'h11, "ip1");
        push(64'h12, "ip2");
        push(64'h13, "ip3");
        check("intr_below", 64'(intr_req), 64'd0);
        push(64'h14, "ip4");
        check("intr_at4", 64'(intr_req), 64'(INTR));
        tick();
        check("intr_hold", 64'(intr_req), 64'(INTR));
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        check("intr_acked", 64'(intr_req), 64'd0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("intr_occ3", 64'(intr_req), 64'd0);
        push(64'h15, "ip5");
        check("intr_rearm", 64'(intr_req), 64'(INTR));
        push(64'h16, "ip6");
        push(64'h17, "ip7");
        check("intr_at6", 64'(intr_req), 64'(INTR));

        // async reset with 6 held
        addr   = A_OCC;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("pre_rst_ack", 64'(rd_ack), 64'd1);
        check("pre_rst_occ", 64'(rdata), 64'd6);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        out_ack  = 1'b1;
        #1;
        check("arst_in_ack", 64'(in_ack), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_rd_ack", 64'(rd_ack), 64'd0);
        check("arst_user_data", 64'(rdata), 64'd0);
        check("arst_intr", 64'(intr_req), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_ack = 1'b0;
        in_data = 64'h77;
        addr    = A_OCC;
        rd_req  = 1'b1;
        #1;
        check("post_rst_ack", 64'(in_ack), 64'd1);
        tick();
        rd_req   = 1'b0;
        in_valid = 1'b0;
        check("post_rst_rd_ack", 64'(rd_ack), 64'd1);
        check("post_rst_occ", 64'(rdata), 64'd0);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", out_data, 64'h77);
        reg_read(A_THR, INTR ? 32'd8 : 32'd0, "post_rst_thresh");
        reg_read(A_CTRL, 32'd1, "post_rst_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
